uart_cmd_asm: RTL and testbench
===============================

UART_CMD_ASM -- requirements
Module: uart_cmd_asm

Interface
REQ-001 Parameter TMO_CYC, default 78120, inter-byte timeout in clk cycles (three byte times at 2604 clk/bit).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_data  input  8  received byte from the upstream UART receiver.
REQ-005 rx_rdy  input  1  upstream byte-valid level; stays high until cleared.
REQ-006 rx_clr_rdy  output  1  one-cycle pulse that acknowledges the byte on rx_data.
REQ-007 cmd  output  16  assembled command, high byte first.
REQ-008 cmd_rdy  output  1  level; a valid command is held on cmd.
REQ-009 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-010 frm_err  output  1  one-cycle pulse on a checksum failure or a timeout.
REQ-011 cmd_ovr  output  1  one-cycle pulse when a new valid command overwrites an unacknowledged one.

Function
REQ-012 A frame is three bytes: HI, LO, CHK; it is valid when (HI+LO+CHK) mod 256 == 0x00.
REQ-013 State machine states: IDLE, WAIT_LO, WAIT_CHK; reset state is IDLE.
REQ-014 IDLE, rx_rdy=1: capture rx_data into hi_byte; next state WAIT_LO.
REQ-015 WAIT_LO, rx_rdy=1: capture rx_data into lo_byte; next state WAIT_CHK.
REQ-016 WAIT_CHK, rx_rdy=1: perform the checksum test; next state IDLE in all cases.
REQ-017 rx_clr_rdy is combinational and equals rx_rdy in every state, so each byte is consumed exactly once, in the cycle it is seen.
REQ-018 Valid checksum: cmd <= {hi_byte, lo_byte} and cmd_rdy <= 1 on the same edge; cmd_rdy rises 1 cycle after the CHK byte's rx_rdy cycle.
REQ-019 Invalid checksum: frm_err pulses for 1 cycle, coincident with the edge that returns to IDLE; cmd and cmd_rdy are unchanged.
REQ-020 Timer: 17-bit; cleared on every byte capture and while in IDLE; increments each cycle in WAIT_LO and WAIT_CHK.
REQ-021 Timeout: timer == TMO_CYC-1 with rx_rdy=0 → next state IDLE, frm_err pulses for 1 cycle, partial bytes are discarded.
REQ-022 A byte arriving in the same cycle as the timeout wins: the byte is captured and no timeout occurs.
REQ-023 cmd_rdy is a set/clear flop: cleared by clr_cmd_rdy; set on a valid frame; when set and clear occur together, set wins.
REQ-024 A valid frame completing while cmd_rdy=1 and clr_cmd_rdy=0: cmd is overwritten and cmd_ovr pulses for 1 cycle.
REQ-025 cmd holds its value between valid frames; it never changes on an error.
REQ-026 Throughput: one byte per cycle is accepted; back-to-back rx_rdy cycles are legal.

Reset
REQ-027 Asserting rst_n low, including mid-frame: state=IDLE, hi_byte=lo_byte=0x00, timer=0, cmd=0x0000, cmd_rdy=0, frm_err=0, cmd_ovr=0.
REQ-028 During reset, rx_clr_rdy follows rx_rdy combinationally; no frame state survives reset.

Structure
REQ-029 The state enum and the TMO_CYC default shall live in shared package uart_cmd_pkg.
REQ-030 The checksum test shall be an inline combinational expression, not a sub-module.
REQ-031 The timeout counter shall be the single sub-module, uart_tmo_cnt, with ports clk, rst_n, clr, en, expired.

Verification
REQ-032 Valid frame: HI=0x12, LO=0x34, CHK=0xBA → cmd=0x1234, cmd_rdy=1 one cycle after CHK, three rx_clr_rdy pulses, no frm_err.
REQ-033 Bad checksum: HI=0x12, LO=0x34, CHK=0x00 → frm_err pulses once, cmd_rdy stays 0, state returns to IDLE, cmd unchanged.
REQ-034 Timeout: HI=0xAB, then silence for TMO_CYC cycles → frm_err pulses at cycle TMO_CYC; a following frame 0x01, 0x02, 0xFD yields cmd=0x0102.
REQ-035 Overrun and priority: two valid frames, 0x1234 then 0x5678 (CHK=0x32), with no clr_cmd_rdy → cmd=0x5678 and cmd_ovr pulses; clr_cmd_rdy on the completing edge → cmd_rdy stays 1.
REQ-036 Reset mid-frame: rst_n pulsed low after HI=0x12 → cmd=0x0000, cmd_rdy=0; a following frame 0x12, 0x34, 0xBA yields cmd=0x1234.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command assembler.
package uart_cmd_pkg;

    localparam int unsigned TMO_CYC_DEF = 78120;
    localparam int unsigned TMR_W       = 17;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLo,
        StWaitChk
    } state_e;

endpackage

// File: rtl/uart_tmo_cnt.sv
// Inter-byte timeout counter: clears on clr, counts on en, flags the last cycle before timeout.
module uart_tmo_cnt
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TMR_W'(TMO_CYC - 1));

endmodule

// File: rtl/uart_cmd_asm.sv
// Assembles HI/LO/CHK byte frames from a UART receiver into 16-bit commands.
module uart_cmd_asm
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_clr_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_err,
    output logic        cmd_ovr
);

    state_e      state_q, state_d;
    logic [7:0]  hi_q, hi_d, lo_q, lo_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        cmd_ovr_q, cmd_ovr_d;
    logic [7:0]  sum;
    logic        frame_ok;
    logic        tmo;
    logic        expired;

    // Every byte is consumed in the cycle it is presented, whatever the state.
    assign rx_clr_rdy = rx_rdy;
    assign sum        = hi_q + lo_q + rx_data;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        frm_err_d = 1'b0;
        cmd_ovr_d = 1'b0;
        frame_ok  = 1'b0;
        tmo       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_rdy) begin
                    hi_d    = rx_data;
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (rx_rdy) begin
                    lo_d    = rx_data;
                    state_d = StWaitChk;
                end else if (expired) begin
                    tmo = 1'b1;
                end
            end
            StWaitChk: begin
                if (rx_rdy) begin
                    state_d = StIdle;
                    if (sum == 8'h00) begin
                        frame_ok = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else if (expired) begin
                    tmo = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tmo) begin
            state_d   = StIdle;
            hi_d      = 8'h00;
            lo_d      = 8'h00;
            frm_err_d = 1'b1;
        end

        // A completing frame beats a simultaneous consumer acknowledge.
        if (frame_ok) begin
            cmd_d     = {hi_q, lo_q};
            cmd_rdy_d = 1'b1;
            cmd_ovr_d = cmd_rdy_q && !clr_cmd_rdy;
        end else if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
            cmd_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
            cmd_ovr_q <= cmd_ovr_d;
        end
    end

    uart_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state_q == StIdle) || rx_rdy || tmo),
        .en      (state_q != StIdle),
        .expired (expired)
    );

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;
    assign cmd_ovr = cmd_ovr_q;

endmodule

// File: tb/tb_uart_cmd_asm.sv
// Directed self-checking bench for uart_cmd_asm using a short timeout.
module tb_uart_cmd_asm;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        rx_clr_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        frm_err;
    logic        cmd_ovr;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    uart_cmd_asm #(
        .TMO_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rx_clr_rdy  (rx_clr_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frm_err     (frm_err),
        .cmd_ovr     (cmd_ovr)
    );

    always @(posedge clk) begin
        if (rx_clr_rdy) clr_pulses <= clr_pulses + 1;
        if (frm_err) err_pulses <= err_pulses + 1;
    end

    // Called just after a negedge; presents one byte for one cycle.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1;
        checks++;
        if (rx_clr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_clr_rdy byte=%h got=%b exp=1", b, rx_clr_rdy);
        end
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic consume();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL consume_cmd_rdy got=%b exp=0", cmd_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rx_rdy = 1'b1;
        #2;
        checks++;
        if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || frm_err !== 1'b0 || cmd_ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0000/0/0/0",
                     cmd, cmd_rdy, frm_err, cmd_ovr);
        end
        checks++;
        if (rx_clr_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_clr_follow_hi got=%b exp=1", rx_clr_rdy);
        end
        rx_rdy = 1'b0;
        #1;
        checks++;
        if (rx_clr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_clr_follow_lo got=%b exp=0", rx_clr_rdy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_valid();
        int c0 = clr_pulses;
        int e0 = err_pulses;
        send(8'h12);
        send(8'h34);
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL valid_early_rdy got=%b exp=0", cmd_rdy);
        end
        send(8'hBA);
        checks++;
        if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL valid_cmd got=%h/%b exp=1234/1", cmd, cmd_rdy);
        end
        @(negedge clk);
        checks++;
        if (clr_pulses - c0 != 3 || err_pulses != e0) begin
            errors++;
            $display("FAIL valid_pulses clr=%0d err=%0d exp=3/0", clr_pulses - c0, err_pulses - e0);
        end
        consume();
        checks++;
        if (cmd !== 16'h1234) begin
            errors++;
            $display("FAIL valid_hold got=%h exp=1234", cmd);
        end
    endtask

    task automatic test_bad_chk();
        int e0 = err_pulses;
        send(8'h12);
        send(8'h34);
        send(8'h00);
        checks++;
        if (frm_err !== 1'b1 || cmd !== 16'h1234 || cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk got err=%b cmd=%h rdy=%b exp=1/1234/0", frm_err, cmd, cmd_rdy);
        end
        @(negedge clk);
        checks++;
        if (frm_err !== 1'b0 || err_pulses - e0 != 1) begin
            errors++;
            $display("FAIL bad_chk_pulse got=%b n=%0d exp=0/1", frm_err, err_pulses - e0);
        end
        send(8'hAA);
        send(8'h55);
        send(8'h01);
        checks++;
        if (cmd !== 16'hAA55 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bad_chk_recover got=%h/%b exp=aa55/1", cmd, cmd_rdy);
        end
        consume();
    endtask

    task automatic test_timeout();
        send(8'hAB);
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (frm_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got=%b exp=0", frm_err);
        end
        @(negedge clk);
        checks++;
        if (frm_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse got=%b exp=1", frm_err);
        end
        @(negedge clk);
        checks++;
        if (frm_err !== 1'b0 || cmd !== 16'hAA55) begin
            errors++;
            $display("FAIL tmo_after got=%b/%h exp=0/aa55", frm_err, cmd);
        end
        send(8'h01);
        send(8'h02);
        send(8'hFD);
        checks++;
        if (cmd !== 16'h0102 || cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next got=%h/%b exp=0102/1", cmd, cmd_rdy);
        end
        consume();
    endtask

    task automatic test_tmo_race();
        int e0 = err_pulses;
        send(8'h11);
        repeat (TMO - 1) @(negedge clk);
        send(8'h22);
        send(8'hCD);
        checks++;
        if (cmd !== 16'h1122 || cmd_rdy !== 1'b1 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_race got=%h/%b/%b exp=1122/1/0", cmd, cmd_rdy, frm_err);
        end
        @(negedge clk);
        checks++;
        if (err_pulses != e0) begin
            errors++;
            $display("FAIL tmo_race_err got=%0d exp=0", err_pulses - e0);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        send(8'h12);
        send(8'h34);
        send(8'hBA);
        send(8'h56);
        send(8'h78);
        send(8'h32);
        checks++;
        if (cmd !== 16'h5678 || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun got=%h/%b/%b exp=5678/1/1", cmd, cmd_rdy, cmd_ovr);
        end
        @(negedge clk);
        checks++;
        if (cmd_ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse got=%b exp=0", cmd_ovr);
        end
        send(8'h9A);
        send(8'hBC);
        clr_cmd_rdy = 1'b1;
        send(8'hAA);
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd !== 16'h9ABC || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b0) begin
            errors++;
            $display("FAIL set_wins got=%h/%b/%b exp=9abc/1/0", cmd, cmd_rdy, cmd_ovr);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h12);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd !== 16'h0000 || cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got=%h/%b exp=0000/0", cmd, cmd_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h12);
        send(8'h34);
        send(8'hBA);
        checks++;
        if (cmd !== 16'h1234 || cmd_rdy !== 1'b1 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next got=%h/%b/%b exp=1234/1/0", cmd, cmd_rdy, frm_err);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_chk();
        test_timeout();
        test_tmo_race();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
